// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types, constants and helpers for the ex target driver
// Purpose : driver FSM state type, 2-bit `ex` state constants, the `ex`
//           next-state function and the directed steering policy.
// Ports   : none (package).
package ex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } drv_state_t;

    localparam logic [1:0] S00 = 2'b00;
    localparam logic [1:0] S01 = 2'b01;
    localparam logic [1:0] S10 = 2'b10;
    localparam logic [1:0] S11 = 2'b11;

    // Feedback taps for x^8+x^6+x^5+x^4+1 on a left-shifting register:
    // bits 7, 5, 4 and 3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Reference behaviour of `ex`: s1 toggles, s0_next = ~(a & s0).
    function automatic logic [1:0] ex_next(input logic [1:0] state, input logic a);
        return {~state[1], ~(a & state[0])};
    endfunction

    // With a=0 the machine always lands on x1, so a=1 is only needed to
    // clear s0: 01->10 and 11->00.
    function automatic logic directed_a(input logic [1:0] state, input logic [1:0] target);
        return ((state == S01) && (target == S10)) ||
               ((state == S11) && (target == S00));
    endfunction

endpackage

// File: rtl/ex_lfsr8.sv
// rtl/ex_lfsr8.sv - 8-bit Fibonacci LFSR for the random steering policy
// Purpose : x^8+x^6+x^5+x^4+1, shifts left with feedback into bit 0.
// Ports   : clock  - rising-edge clock
//           reset  - synchronous active-high, reloads the seed
//           enable - advance one step
//           seed   - reload value (0 is replaced by 8'h01)
//           q      - current register value
module ex_lfsr8
    import ex_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] r_q;
    logic [7:0] w_seed;
    logic       w_fb;

    // An all-zero state would lock the register up.
    assign w_seed = (seed == 8'h00) ? 8'h01 : seed;
    assign w_fb   = ^(r_q & LFSR_TAPS);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= w_seed;
        end else if (enable) begin
            r_q <= {r_q[6:0], w_fb};
        end
    end

    assign q = r_q;

endmodule

// File: rtl/ex_target_driver.sv
// rtl/ex_target_driver.sv - steers the 2-bit `ex` machine to a commanded state
// Purpose : on start, drives `ex` input `a` (directed or LFSR policy) until
//           the observed state matches the target or the run times out.
// Ports   : clock, reset (sync, active-high)
//           start, target[1:0], mode  - request, latched in IDLE only
//           state_in[1:0]             - observed {s1,s0} of `ex`
//           a_out                     - drives `ex` input a (combinational)
//           busy, done                - RUN indicator, one-cycle completion pulse
//           reached, cycles[CNT_W-1:0]- run result
module ex_target_driver
    import ex_pkg::*;
#(
    parameter int         CNT_W      = 8,
    parameter int         MAX_CYCLES = 20,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       target,
    input  logic             mode,
    input  logic [1:0]       state_in,
    output logic             a_out,
    output logic             busy,
    output logic             done,
    output logic             reached,
    output logic [CNT_W-1:0] cycles
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] MAX_COUNT  = CNT_W'(MAX_CYCLES);

    drv_state_t       r_state;
    drv_state_t       w_next_state;
    logic [1:0]       r_target;
    logic             r_mode;
    logic [CNT_W-1:0] r_count;
    logic             r_reached;
    logic [CNT_W-1:0] r_cycles;

    logic             w_match;
    logic             w_timeout;
    logic             w_lfsr_en;
    logic [7:0]       w_lfsr;
    logic             w_rand_bit;

    ex_lfsr8 u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (w_lfsr_en),
        .seed   (LFSR_SEED),
        .q      (w_lfsr)
    );

    // Only bit 0 of the LFSR feeds `a`.
    assign w_rand_bit = |(w_lfsr & 8'h01);

    always_comb begin
        w_next_state = r_state;
        w_match      = 1'b0;
        w_timeout    = 1'b0;
        w_lfsr_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                // Match outranks timeout on the same cycle.
                if (state_in == r_target) begin
                    w_match      = 1'b1;
                    w_next_state = ST_DONE;
                end else if (r_count == LAST_COUNT) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_DONE;
                end else begin
                    w_lfsr_en    = 1'b1;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_target  <= S00;
            r_mode    <= 1'b0;
            r_count   <= '0;
            r_reached <= 1'b0;
            r_cycles  <= '0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == ST_IDLE) && start) begin
                r_target  <= target;
                r_mode    <= mode;
                r_count   <= '0;
                r_reached <= 1'b0;
            end else if (r_state == ST_RUN) begin
                if (w_match) begin
                    r_reached <= 1'b1;
                    r_cycles  <= r_count;
                end else if (w_timeout) begin
                    r_reached <= 1'b0;
                    r_cycles  <= MAX_COUNT;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    always_comb begin
        a_out = 1'b0;
        if (r_state == ST_RUN) begin
            a_out = r_mode ? w_rand_bit : directed_a(state_in, r_target);
        end
    end

    assign busy    = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);
    assign reached = r_reached;
    assign cycles  = r_cycles;

endmodule

// File: tb/tb_ex_target_driver.sv
// tb/tb_ex_target_driver.sv - self-checking bench for ex_target_driver
module tb_ex_target_driver;

    localparam int MAX = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       start4 = 1'b0;
    logic [1:0] target = 2'b00;
    logic       mode = 1'b0;
    logic [1:0] state_in = 2'b00;

    logic       a_out, busy, done, reached;
    logic [7:0] cycles;
    logic       a_out4, busy4, done4, reached4;
    logic [7:0] cycles4;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_lfsr;

    always #5 clock = ~clock;

    ex_target_driver #(.CNT_W(8), .MAX_CYCLES(MAX), .LFSR_SEED(8'hA5)) dut (
        .clock(clock), .reset(reset), .start(start), .target(target), .mode(mode),
        .state_in(state_in), .a_out(a_out), .busy(busy), .done(done),
        .reached(reached), .cycles(cycles)
    );

    ex_target_driver #(.CNT_W(8), .MAX_CYCLES(4), .LFSR_SEED(8'hA5)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .target(target), .mode(mode),
        .state_in(state_in), .a_out(a_out4), .busy(busy4), .done(done4),
        .reached(reached4), .cycles(cycles4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [1:0] m_next(input logic [1:0] s, input logic a);
        logic s1n, s0n;
        s1n = (s[1] == 1'b0);
        s0n = !(a && s[0]);
        return {s1n, s0n};
    endfunction

    // Directed policy written as a lookup: a=1 only for 01->10 and 11->00.
    function automatic logic m_pol(input logic [1:0] s, input logic [1:0] t);
        logic [15:0] tab;
        tab = 16'b0000_0000_0000_0000;
        tab[4'b0110] = 1'b1;
        tab[4'b1100] = 1'b1;
        return tab[{s, t}];
    endfunction

    function automatic logic [7:0] m_lfsr_next(input logic [7:0] v);
        int fb;
        fb = (v[7] + v[5] + v[4] + v[3]) % 2;
        return ((v * 2) % 256) + fb;
    endfunction

    task automatic do_run(input logic [1:0] init, input logic [1:0] tgt, input logic md,
                          input bit poke, output int obs_cyc, output int obs_reached);
        logic [1:0] s;
        logic [7:0] l;
        int         n;
        logic       a;
        logic       exp_r;
        int         exp_c;
        logic       aq[$];
        s = init; l = m_lfsr; n = 0; exp_r = 1'b0; exp_c = 0;
        for (int g = 0; g < 64; g++) begin
            a = md ? l[0] : m_pol(s, tgt);
            aq.push_back(a);
            if (s == tgt) begin exp_r = 1'b1; exp_c = n; break; end
            if (n == MAX - 1) begin exp_r = 1'b0; exp_c = MAX; break; end
            s = m_next(s, a);
            l = m_lfsr_next(l);
            n++;
        end
        m_lfsr = l;

        @(negedge clock);
        start = 1'b1; target = tgt; mode = md; state_in = init;
        @(posedge clock); #1;
        start = poke;
        if (poke) begin target = ~tgt; mode = ~md; end
        for (int i = 0; i < aq.size(); i++) begin
            @(negedge clock);
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_a_out", a_out, aq[i]);
            @(posedge clock); #1;
            state_in = m_next(state_in, aq[i]);
        end
        @(negedge clock);
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_reached", reached, exp_r);
        chk("end_cycles", cycles, exp_c);
        obs_cyc = cycles;
        obs_reached = reached;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            chk("post_done", done, 0);
            chk("post_busy", busy, 0);
            chk("post_a_out", a_out, 0);
        end
    endtask

    typedef struct {
        logic [1:0] init;
        logic [1:0] tgt;
        int         exp_cyc;
    } vec_t;

    initial begin
        vec_t vecs[16];
        int   exp_tab[16] = '{0, 2, 3, 1,  2, 0, 1, 1,  3, 1, 0, 2,  1, 1, 2, 0};
        int   oc, orr;

        for (int i = 0; i < 16; i++) begin
            vecs[i].init    = 2'(i >> 2);
            vecs[i].tgt     = 2'(i & 3);
            vecs[i].exp_cyc = exp_tab[i];
        end

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_reached", reached, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_a_out", a_out, 0);
        chk("rst_busy4", busy4, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        m_lfsr = 8'hA5;

        // Random mode from a fresh seed: 00 -> 10
        do_run(2'b00, 2'b10, 1'b1, 1'b0, oc, orr);

        // Directed mode from every start state to every target
        for (int i = 0; i < 16; i++) begin
            do_run(vecs[i].init, vecs[i].tgt, 1'b0, 1'b0, oc, orr);
            chk("tab_cycles", oc, vecs[i].exp_cyc);
            chk("tab_reached", orr, 1);
        end

        // Start pulses during RUN and DONE with a different target/mode
        do_run(2'b10, 2'b00, 1'b0, 1'b1, oc, orr);
        chk("poke_cycles", oc, 3);
        do_run(2'b00, 2'b10, 1'b1, 1'b1, oc, orr);

        // Reset on the first RUN cycle
        @(negedge clock);
        start = 1'b1; target = 2'b10; mode = 1'b1; state_in = 2'b00;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        chk("mid_busy_before", busy, 1);
        reset = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_reached", reached, 0);
        chk("mid_cycles", cycles, 0);
        chk("mid_a_out", a_out, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        m_lfsr = 8'hA5;
        @(negedge clock);
        chk("mid_no_done", done, 0);
        do_run(2'b00, 2'b10, 1'b1, 1'b0, oc, orr);

        // Randomized runs
        for (int r = 0; r < 24; r++) begin
            do_run(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), oc, orr);
        end

        // Timeout on the MAX_CYCLES=4 instance with state_in stuck at 00
        @(negedge clock);
        start4 = 1'b1; target = 2'b10; mode = 1'b1; state_in = 2'b00;
        @(posedge clock); #1;
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("to_busy", busy4, 1);
            chk("to_done", done4, 0);
        end
        @(negedge clock);
        chk("to_end_done", done4, 1);
        chk("to_end_reached", reached4, 0);
        chk("to_end_cycles", cycles4, 4);
        chk("to_end_busy", busy4, 0);
        @(negedge clock);
        chk("to_post_done", done4, 0);
        chk("to_post_busy", busy4, 0);
        chk("to_post_a_out", a_out4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
